fetch_queue: RTL

Instruction fetch queue that sits between the program counter / instruction memory pair and the decode stage. Each cycle it can accept one fetched (pc, instruction) pair from the fetch side and deliver one to decode, buffering up to DEPTH pairs so that decode stalls do not force the fetch side to stall at once. It also tags each entry with an instruction-fetch address exception and supports a single-cycle flush on control-flow redirect.

---
 rtl/fetch_queue.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of (pc, instr, adel) between fetch and decode.
// Flush on redirect empties the queue on the next edge and discards any same-cycle push.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic          adel_q  [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop, in_adel;

  always_comb begin
    in_ready  = (count_q != Full);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    in_adel   = (in_pc[1:0] != 2'b00) || (in_pc < IM_BASE) || (in_pc > IM_LIMIT);
    out_pc    = pc_q[rd_ptr_q];
    out_instr = instr_q[rd_ptr_q];
    out_adel  = adel_q[rd_ptr_q];
    count     = count_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are reset so the empty head shows RESET_PC / zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= RESET_PC;
        instr_q[i] <= '0;
        adel_q[i]  <= 1'b0;
      end
    end else if (push && !flush) begin
      pc_q[wr_ptr_q]    <= in_pc;
      instr_q[wr_ptr_q] <= in_instr;
      adel_q[wr_ptr_q]  <= in_adel;
    end
  end

endmodule
